// File: rtl/pwm_ramp_sequencer.sv
// Per-channel duty ramp controller: on each update tick, moves every channel's duty
// toward its target by at most G_STEP and emits one AXIS beat per changed channel.
module pwm_ramp_sequencer #(
  parameter int G_NUM_CHANNELS         = 4,
  parameter int G_UPDATE_PERIOD_CYCLES = 1000,
  parameter int G_STEP                 = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  input  logic [3:0]                cfg_channel,
  input  logic [15:0]               cfg_target,
  output logic                      cfg_ready,
  output logic                      axis_out_tvalid,
  output logic [23:0]               axis_out_tdata,
  input  logic                      axis_out_tready,
  output logic                      busy,
  output logic [G_NUM_CHANNELS-1:0] ramp_done
);

  // state | meaning
  // IDLE  | waiting for an update tick or a pending tick
  // SCAN  | comparing cur/tgt of channel idx, one channel per cycle
  // SEND  | beat for channel idx presented, waiting for tready

  localparam int IW    = (G_NUM_CHANNELS > 1) ? $clog2(G_NUM_CHANNELS) : 1;
  localparam int NSLOT = 1 << IW;
  localparam int CW    = (G_UPDATE_PERIOD_CYCLES > 1) ? $clog2(G_UPDATE_PERIOD_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(G_UPDATE_PERIOD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(G_NUM_CHANNELS - 1);
  localparam logic [16:0]   STEP17   = 17'(G_STEP);
  localparam logic [4:0]    NUM_CH5  = 5'(G_NUM_CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SEND
  } state_t;

  state_t         state_q;
  logic [IW-1:0]  idx_q;
  logic           pending_q;
  logic [CW-1:0]  cnt_q;
  logic           tvalid_q;
  logic [23:0]    tdata_q;
  logic [15:0]    cur_q [NSLOT];
  logic [15:0]    tgt_q [NSLOT];

  logic           tick;
  logic           cfg_hit;
  logic [15:0]    cur_sel;
  logic [15:0]    tgt_sel;
  logic [16:0]    gap;
  logic [16:0]    step;
  logic [15:0]    duty_d;

  assign tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cfg_hit = cfg_valid && ({1'b0, cfg_channel} < NUM_CH5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        tgt_q[i] <= '0;
      end
    end else if (cfg_hit) begin
      tgt_q[cfg_channel[IW-1:0]] <= cfg_target;
    end
  end

  assign cur_sel = cur_q[idx_q];
  assign tgt_sel = tgt_q[idx_q];

  // 17-bit arithmetic so the clamped step can neither wrap nor overshoot.
  always_comb begin
    gap    = '0;
    step   = '0;
    duty_d = cur_sel;
    if (tgt_sel > cur_sel) begin
      gap    = {1'b0, tgt_sel} - {1'b0, cur_sel};
      step   = (gap < STEP17) ? gap : STEP17;
      duty_d = 16'({1'b0, cur_sel} + step);
    end else begin
      gap    = {1'b0, cur_sel} - {1'b0, tgt_sel};
      step   = (gap < STEP17) ? gap : STEP17;
      duty_d = 16'({1'b0, cur_sel} - step);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        cur_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick || pending_q) begin
            pending_q <= 1'b0;
            idx_q     <= '0;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (tick) begin
            pending_q <= 1'b1;
          end
          if (cur_sel != tgt_sel) begin
            tdata_q  <= {4'h0, 4'(idx_q), duty_d};
            tvalid_q <= 1'b1;
            state_q  <= ST_SEND;
          end else if (idx_q == IDX_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_SEND: begin
          if (tick) begin
            pending_q <= 1'b1;
          end
          // tvalid is always high here, so tready alone completes the handshake.
          if (axis_out_tready) begin
            cur_q[idx_q] <= tdata_q[15:0];
            tvalid_q     <= 1'b0;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= ST_SCAN;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < G_NUM_CHANNELS; g++) begin : g_done
    assign ramp_done[g] = (cur_q[g] == tgt_q[g]);
  end

  assign busy            = (state_q != ST_IDLE);
  assign cfg_ready       = 1'b1;
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tdata  = tdata_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: procedural sweep model compared every cycle,
// directed scenarios with literal beat lists, then randomized traffic.
module tb_pwm_ramp_sequencer;
  localparam int N    = 4;
  localparam int P    = 8;
  localparam int STEP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [3:0]    cfg_channel = '0;
  logic [15:0]   cfg_target = '0;
  logic          cfg_ready;
  logic          axis_out_tvalid;
  logic [23:0]   axis_out_tdata;
  logic          axis_out_tready = 1'b1;
  logic          busy;
  logic [N-1:0]  ramp_done;

  pwm_ramp_sequencer #(
    .G_NUM_CHANNELS(N),
    .G_UPDATE_PERIOD_CYCLES(P),
    .G_STEP(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_channel(cfg_channel),
    .cfg_target(cfg_target),
    .cfg_ready(cfg_ready),
    .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tdata(axis_out_tdata),
    .axis_out_tready(axis_out_tready),
    .busy(busy),
    .ramp_done(ramp_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cur [N];
  int          m_tgt [N];
  bit          m_pend = 1'b0;
  int          n_cyc = 0;
  bit          e_tvalid = 1'b0;
  bit          e_busy = 1'b0;
  logic [23:0] e_tdata = '0;
  logic [23:0] m_beats [$];
  logic [23:0] d_beats [$];
  logic [23:0] exp_q [$];

  function automatic int next_duty(input int c, input int t);
    if (t > c) return c + (((t - c) < STEP) ? (t - c) : STEP);
    else       return c - (((c - t) < STEP) ? (c - t) : STEP);
  endfunction

  function automatic logic [N-1:0] model_done();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_cur[i] == m_tgt[i]);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_tgt[i] <= 0;
    end else if (cfg_valid && int'(cfg_channel) < N) begin
      m_tgt[int'(cfg_channel)] <= int'(cfg_target);
    end
  end

  // One clock edge of the model; reports reset and whether that edge carried a tick.
  task automatic adv(input bit idle, output bit ab, output bit tk);
    @(posedge clk);
    tk = 1'b0;
    if (rst) begin
      ab = 1'b1;
      n_cyc = 0;
      m_pend = 1'b0;
      e_tvalid = 1'b0;
      e_busy = 1'b0;
      e_tdata = '0;
      for (int i = 0; i < N; i++) m_cur[i] = 0;
    end else begin
      ab = 1'b0;
      tk = ((n_cyc % P) == P - 1);
      n_cyc++;
      if (tk && !idle) m_pend = 1'b1;
    end
  endtask

  initial begin
    bit ab;
    bit tk;
    bit hs;
    int nxt;
    for (int i = 0; i < N; i++) m_cur[i] = 0;
    forever begin
      adv(1'b1, ab, tk);
      if (!ab && (tk || m_pend)) begin
        m_pend = 1'b0;
        e_busy = 1'b1;
        for (int ch = 0; ch < N && !ab; ch++) begin
          adv(1'b0, ab, tk);
          if (!ab && m_cur[ch] != m_tgt[ch]) begin
            nxt = next_duty(m_cur[ch], m_tgt[ch]);
            e_tdata = {4'h0, 4'(ch), 16'(nxt)};
            e_tvalid = 1'b1;
            hs = 1'b0;
            while (!ab && !hs) begin
              adv(1'b0, ab, tk);
              hs = !ab && axis_out_tready;
            end
            if (hs) begin
              m_cur[ch] = nxt;
              m_beats.push_back(e_tdata);
              e_tvalid = 1'b0;
            end
          end
        end
        if (!ab) e_busy = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare and beat monitor ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("tvalid", 32'(axis_out_tvalid), 32'(e_tvalid));
      chk("busy", 32'(busy), 32'(e_busy));
      if (e_tvalid) chk("tdata", 32'(axis_out_tdata), 32'(e_tdata));
      chk("ramp_done", 32'(ramp_done), 32'(model_done()));
      chk("cfg_ready", 32'(cfg_ready), 32'd1);
    end
  end

  logic        s_tv = 1'b0;
  logic [23:0] s_td = '0;
  always @(negedge clk) begin
    s_tv <= axis_out_tvalid;
    s_td <= axis_out_tdata;
  end
  always @(posedge clk) begin
    if (!rst && s_tv && axis_out_tready) d_beats.push_back(s_td);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int v);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_channel = 4'(ch);
    cfg_target = 16'(v);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic clr();
    d_beats.delete();
    m_beats.delete();
    exp_q.delete();
  endtask

  task automatic wait_tvalid(input string name);
    int k = 0;
    while (!axis_out_tvalid && k < 4 * P) begin
      @(negedge clk);
      k++;
    end
    chk({name, " tvalid seen"}, 32'(axis_out_tvalid), 32'd1);
  endtask

  task automatic cmp_beats(input string name);
    chk({name, " dut beat count"}, 32'(d_beats.size()), 32'(exp_q.size()));
    chk({name, " model beat count"}, 32'(m_beats.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < d_beats.size()) chk({name, " dut beat"}, 32'(d_beats[i]), 32'(exp_q[i]));
      if (i < m_beats.size()) chk({name, " model beat"}, 32'(m_beats[i]), 32'(exp_q[i]));
    end
    clr();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("reset tvalid", 32'(axis_out_tvalid), 32'd0);
    chk("reset tdata", 32'(axis_out_tdata), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ramp_done", 32'(ramp_done), 32'hF);
    chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // ramp up ch1 to 40
    clr();
    wr(1, 40);
    cyc(4 * P + 4);
    exp_q.push_back(24'h010010);
    exp_q.push_back(24'h010020);
    exp_q.push_back(24'h010028);
    cmp_beats("ramp up");
    chk("ramp up done[1]", 32'(ramp_done[1]), 32'd1);

    // ramp down ch0 from 40 to 0
    wr(0, 40);
    cyc(4 * P + 4);
    clr();
    wr(0, 0);
    cyc(4 * P + 4);
    exp_q.push_back(24'h000018);
    exp_q.push_back(24'h000008);
    exp_q.push_back(24'h000000);
    cmp_beats("ramp down");
    chk("ramp down done", 32'(ramp_done), 32'hF);

    // backpressure on ch2
    axis_out_tready = 1'b0;
    wr(2, 100);
    wait_tvalid("bp");
    chk("bp first tdata", 32'(axis_out_tdata), 32'h020010);
    repeat (30) begin
      @(negedge clk);
      chk("bp tvalid held", 32'(axis_out_tvalid), 32'd1);
      chk("bp tdata held", 32'(axis_out_tdata), 32'h020010);
    end
    axis_out_tready = 1'b1;
    cyc(8 * P);
    for (int v = 16; v <= 96; v += 16) exp_q.push_back({8'h02, 16'(v)});
    exp_q.push_back(24'h020064);
    cmp_beats("backpressure");

    // reset while a beat is stalled
    axis_out_tready = 1'b0;
    wr(3, 50);
    wait_tvalid("mid-send");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst tvalid", 32'(axis_out_tvalid), 32'd0);
    chk("async rst tdata", 32'(axis_out_tdata), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst ramp_done", 32'(ramp_done), 32'hF);
    @(negedge clk);
    #2 rst = 1'b0;
    axis_out_tready = 1'b1;
    clr();
    cyc(3 * P);
    cmp_beats("post reset quiet");

    // two channels in one scan, ascending order
    do_reset();
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_channel = 4'd2;
    cfg_target = 16'd16;
    @(negedge clk);
    cfg_channel = 4'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    cyc(3 * P);
    exp_q.push_back(24'h000010);
    exp_q.push_back(24'h020010);
    cmp_beats("ordering");

    // out-of-range channel
    wr(5, 1234);
    cyc(3 * P);
    cmp_beats("out of range");
    chk("out of range ramp_done", 32'(ramp_done), 32'hF);

    // retarget ch0 while its beat is in flight
    axis_out_tready = 1'b0;
    wr(0, 64);
    wait_tvalid("retarget");
    chk("retarget first tdata", 32'(axis_out_tdata), 32'h000020);
    wr(0, 0);
    cyc(5);
    chk("retarget tdata held", 32'(axis_out_tdata), 32'h000020);
    chk("retarget tvalid held", 32'(axis_out_tvalid), 32'd1);
    axis_out_tready = 1'b1;
    cyc(4 * P);
    exp_q.push_back(24'h000020);
    exp_q.push_back(24'h000010);
    exp_q.push_back(24'h000000);
    cmp_beats("retarget");

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_channel = 4'($urandom_range(0, 5));
      cfg_target = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 120));
      axis_out_tready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 599) == 0) begin
        cfg_valid = 1'b0;
        do_reset();
      end
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    axis_out_tready = 1'b1;
    cyc(4 * P);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
